uart_rx_byte: RTL and testbench

- 8N1 UART receiver; the downstream partner of the team's UART_Tx byte transmitter.
- Samples the asynchronous serial line with 16x oversampling, validates the start bit and majority-votes each bit.
- Delivers each received byte as a one-clock data_valid pulse to the local consumer.
- Flags stop-bit framing errors.
- Runs on the 100 MHz system clock; no derived clocks.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_byte.sv | 151 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate defaults, divider derivation, receiver state
// encoding and the bit-vote helper used by the 8N1 receiver.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEFAULT = 100_000_000;
  localparam int unsigned BAUD_DEFAULT        = 9600;
  localparam int unsigned OVERSAMPLE_DEFAULT  = 16;
  localparam int unsigned DATA_BITS           = 8;
  localparam logic        LINE_IDLE           = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // Clocks per sample tick; truncation error is tiny at the supported rates.
  function automatic int unsigned tick_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_hz / (baud * oversample);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick divider: counts 0..DIV-1 and pulses tick for one clock on wrap.
// A synchronous clear holds the count at zero so the phase restarts on demand.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic clk_100MHZ,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_100MHZ) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST) && !clear;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling, start-bit glitch rejection,
// three-sample majority vote per bit and stop-bit framing-error detection.
`timescale 1ns/1ps
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
  parameter int unsigned BAUD        = BAUD_DEFAULT,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk_100MHZ,
  input  logic                 reset,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy_flag
);

  localparam int unsigned TICK_DIV = tick_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SW       = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_PRE  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_VOTE = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_e state, state_next;

  logic                 sync_1, rx_s;
  logic                 tick, tick_clear;
  logic [SW-1:0]        samp;
  logic                 vote_a, vote_b, vote;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 at_vote, at_end;
  logic                 samp_clr, shift_en, idx_clr, idx_inc, load_byte, frame_err;

  // Two-flop synchronizer; idle-high reset avoids a false start after reset.
  always_ff @(posedge clk_100MHZ) begin
    if (reset) begin
      sync_1 <= LINE_IDLE;
      rx_s   <= LINE_IDLE;
    end else begin
      sync_1 <= rx_serial;
      rx_s   <= sync_1;
    end
  end

  assign tick_clear = (state == IDLE);

  uart_baud_tick #(.DIV(TICK_DIV)) u_baud_tick (
    .clk_100MHZ (clk_100MHZ),
    .reset      (reset),
    .clear      (tick_clear),
    .tick       (tick)
  );

  assign vote    = majority3(vote_a, vote_b, rx_s);
  assign at_vote = tick && (samp == S_VOTE);
  assign at_end  = tick && (samp == S_LAST);

  always_ff @(posedge clk_100MHZ) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    samp_clr   = 1'b0;
    shift_en   = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    load_byte  = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_s != LINE_IDLE) begin
          samp_clr   = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (at_vote && vote) begin
          state_next = IDLE;
        end else if (at_end) begin
          idx_clr    = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        shift_en = at_vote;
        if (at_end) begin
          if (bit_idx == LAST_BIT) state_next = STOP;
          else                     idx_inc    = 1'b1;
        end
      end
      STOP: begin
        // Leave on the mid-stop vote so a following start edge is not missed.
        if (at_vote) begin
          if (vote) begin
            load_byte  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s == LINE_IDLE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHZ) begin
    if (reset) begin
      samp          <= '0;
      vote_a        <= 1'b0;
      vote_b        <= 1'b0;
      bit_idx       <= '0;
      shift         <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy_flag     <= 1'b0;
    end else begin
      data_valid    <= load_byte;
      framing_error <= frame_err;
      busy_flag     <= (state_next != IDLE);

      if (samp_clr)            samp <= '0;
      else if (at_end)         samp <= '0;
      else if (tick)           samp <= samp + 1'b1;

      if (tick && samp == S_PRE) vote_a <= rx_s;
      if (tick && samp == S_MID) vote_b <= rx_s;

      if (shift_en) shift <= {vote, shift[DATA_BITS-1:1]};

      if (idx_clr)      bit_idx <= '0;
      else if (idx_inc) bit_idx <= bit_idx + 1'b1;

      if (load_byte) data_out <= shift;
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: a serial driver pushes expected outcomes
// per frame, an independent monitor pops and compares on every output pulse.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  // Scaled line rate keeps runs short: TICK_DIV = 100e6 / (781250*16) = 8.
  localparam int unsigned CLK_HZ  = 100_000_000;
  localparam int unsigned BAUD_TB = 781_250;
  localparam int unsigned DIV_TB  = CLK_HZ / (BAUD_TB * 16);
  localparam real         CLK_NS  = 10.0;
  localparam real         BIT_NS  = CLK_NS * 16.0 * DIV_TB;
  localparam int unsigned LATENCY = 2 + 1 + (9 * 16 + 9 + 1) * DIV_TB;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  logic       clk_100MHZ = 1'b0;
  logic       reset;
  logic       rx_serial;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       busy_flag;

  exp_t        exp_q[$];
  logic [7:0]  last_good;
  int          n_vec = 0;
  int          n_miss = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned dv_cyc = 0;
  logic        busy_at_dv = 1'b1;

  uart_rx_byte #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD_TB),
    .OVERSAMPLE  (16)
  ) dut (
    .clk_100MHZ    (clk_100MHZ),
    .reset         (reset),
    .rx_serial     (rx_serial),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy_flag     (busy_flag)
  );

  always #(CLK_NS / 2.0) clk_100MHZ = ~clk_100MHZ;
  always @(posedge clk_100MHZ) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a good stop bit delivers the byte, a low stop bit reports
  // a framing error while the last good byte stays on data_out.
  task automatic expect_frame(input logic [7:0] b, input logic stop);
    exp_t e;
    if (stop) begin
      e.ferr = 1'b0; e.data = b; last_good = b;
    end else begin
      e.ferr = 1'b1; e.data = last_good;
    end
    exp_q.push_back(e);
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; the line is left at
  // the stop-bit level. noise_bit >= 0 inverts one tick around sample 8.
  task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns,
                            input int noise_bit, input logic align);
    logic [9:0] f;
    real pre, tk;
    f = {stop, b, 1'b0};
    tk  = bit_ns / 16.0;
    pre = tk * 8.5 + 9.0;
    if (align) begin
      @(posedge clk_100MHZ);
      #1;
    end
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_serial = f[i];
      if (i == noise_bit + 1) begin
        #(pre);
        rx_serial = ~f[i];
        #(tk);
        rx_serial = f[i];
        #(bit_ns - pre - tk);
      end else begin
        #(bit_ns);
      end
    end
  endtask

  always @(negedge clk_100MHZ) begin
    if (!reset && (data_valid || framing_error)) begin
      check("dv_fe_exclusive", 32'(data_valid & framing_error), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, data_valid, framing_error}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.ferr) begin
          check("ferr_pulse", 32'(framing_error), 32'd1);
          check("ferr_data_held", 32'(data_out), 32'(e.data));
        end else begin
          check("dv_pulse", 32'(data_valid), 32'd1);
          check("rx_byte", 32'(data_out), 32'(e.data));
          dv_cyc     = cyc;
          busy_at_dv = busy_flag;
        end
      end
    end
  end

  initial begin
    #(3_000_000.0);
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic       rstop;
    real        bt;
    int         gap;
    logic [9:0] pf;

    reset = 1'b1;
    rx_serial = 1'b1;
    last_good = 8'h00;
    repeat (4) @(posedge clk_100MHZ);
    @(negedge clk_100MHZ);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_data_valid", 32'(data_valid), 32'd0);
    check("reset_framing_error", 32'(framing_error), 32'd0);
    check("reset_busy", 32'(busy_flag), 32'd0);
    reset = 1'b0;
    #(BIT_NS);

    // Good byte with latency and busy window
    expect_frame(8'hA5, 1'b1);
    fork
      send_frame(8'hA5, 1'b1, BIT_NS, -1, 1'b1);
      begin
        repeat (600) @(negedge clk_100MHZ);
        check("busy_mid_frame", 32'(busy_flag), 32'd1);
      end
    join
    #(BIT_NS);
    check("latency_a5", dv_cyc - start_cyc, LATENCY);
    check("busy_low_at_dv", 32'(busy_at_dv), 32'd0);
    check("busy_low_after", 32'(busy_flag), 32'd0);

    // Back-to-back frames, no idle gap
    expect_frame(8'h00, 1'b1);
    expect_frame(8'hFF, 1'b1);
    expect_frame(8'h55, 1'b1);
    send_frame(8'h00, 1'b1, BIT_NS, -1, 1'b1);
    send_frame(8'hFF, 1'b1, BIT_NS, -1, 1'b0);
    send_frame(8'h55, 1'b1, BIT_NS, -1, 1'b0);
    #(2.0 * BIT_NS);

    // Short low glitch on an idle line
    @(posedge clk_100MHZ);
    #1;
    rx_serial = 1'b0;
    #(120.0);
    rx_serial = 1'b1;
    #(BIT_NS);
    check("glitch_back_to_idle", 32'(busy_flag), 32'd0);
    expect_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1, BIT_NS, -1, 1'b1);
    #(BIT_NS);

    // Framing error followed by a break
    expect_frame(8'h11, 1'b1);
    send_frame(8'h11, 1'b1, BIT_NS, -1, 1'b1);
    #(BIT_NS);
    expect_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0, BIT_NS, -1, 1'b1);
    #(3.0 * BIT_NS);
    check("busy_during_break", 32'(busy_flag), 32'd1);
    rx_serial = 1'b1;
    #(BIT_NS / 2.0);
    check("idle_after_break", 32'(busy_flag), 32'd0);
    #(BIT_NS);
    expect_frame(8'h7E, 1'b1);
    send_frame(8'h7E, 1'b1, BIT_NS, -1, 1'b1);
    #(BIT_NS);

    // Single-sample inversion in bit 2 is outvoted
    expect_frame(8'hC3, 1'b1);
    send_frame(8'hC3, 1'b1, BIT_NS, 2, 1'b1);
    #(BIT_NS);

    // Reset in the middle of data bit 4
    pf = {1'b1, 8'h5A, 1'b0};
    @(posedge clk_100MHZ);
    #1;
    for (int i = 0; i < 5; i++) begin
      rx_serial = pf[i];
      #(BIT_NS);
    end
    rx_serial = pf[5];
    #(BIT_NS / 2.0);
    @(posedge clk_100MHZ);
    #1;
    reset = 1'b1;
    @(posedge clk_100MHZ);
    @(negedge clk_100MHZ);
    check("midreset_data_out", 32'(data_out), 32'd0);
    check("midreset_data_valid", 32'(data_valid), 32'd0);
    check("midreset_framing_error", 32'(framing_error), 32'd0);
    check("midreset_busy", 32'(busy_flag), 32'd0);
    reset = 1'b0;
    rx_serial = 1'b1;
    last_good = 8'h00;
    #(2.0 * BIT_NS);
    expect_frame(8'h9A, 1'b1);
    send_frame(8'h9A, 1'b1, BIT_NS, -1, 1'b1);
    #(BIT_NS);

    // Transmitter 2% fast and 2% slow
    expect_frame(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1, BIT_NS * 0.98, -1, 1'b1);
    #(BIT_NS);
    expect_frame(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1, BIT_NS * 1.02, -1, 1'b1);
    #(BIT_NS);

    // Random bytes, stop-bit validity, skew and gaps
    for (int n = 0; n < 12; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      bt    = BIT_NS * (1.0 + (real'($urandom_range(0, 400)) - 200.0) / 10000.0);
      gap   = int'($urandom_range(1, 3));
      expect_frame(rb, rstop);
      send_frame(rb, rstop, bt, -1, 1'b1);
      rx_serial = 1'b1;
      #(real'(gap) * BIT_NS);
    end

    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk_100MHZ);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(busy_flag), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
